xalu: RTL and testbench
=======================

# xalu

Multi-cycle multiply/divide unit with the HI/LO register pair, sitting in the E stage of the five-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the DE pipeline register. It runs multiplies and divides over a fixed number of cycles and raises `Busy` and `Start`. The hazard unit combines these with its own HI/LO-class decode of the FD instruction to stall D-stage HI/LO instructions.

## Interface

Parameters:
- MULT_CYCLES, 5, cycles `Busy` stays high for mult/multu
- DIV_CYCLES, 10, cycles `Busy` stays high for div/divu

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock; clears all state
- A  input  32  forwarded rs value (E stage)
- B  input  32  forwarded rt value (E stage)
- XOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9–15 treated as none
- IntReq  input  1  exception/interrupt taken this cycle; the E-stage instruction must not commit
- Start  output  1  combinational: XOp ∈ {1..4} and not IntReq
- Busy  output  1  registered: a multiply/divide is in progress
- HI  output  32  HI register
- LO  output  32  LO register
- XOut  output  32  combinational: HI when XOp=7, LO when XOp=8, else 0

## Operation

- Reset: HI=0, LO=0, Busy=0, cycle counter=0, pending result=0.
- States: IDLE (Busy=0) and RUN (Busy=1).
- IDLE, XOp∈{1..4}, IntReq=0:
  - At the edge, latch the pending result into internal registers:
    - mult: signed 64-bit A×B.
    - multu: unsigned 64-bit A×B.
    - div: LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
    - divu: unsigned quotient and remainder.
  - Load the counter with MULT_CYCLES or DIV_CYCLES and enter RUN.
- RUN: decrement the counter each edge. On the edge where the counter reaches 1→0, write the pending {HI,LO}, clear Busy and return to IDLE.
- Divide by zero (B=0, div/divu): the operation runs its full DIV_CYCLES. HI and LO keep their pre-operation values.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo (IDLE, IntReq=0): write A into HI or LO at the edge. No Busy.
- mfhi/mflo: read only. XOut reflects the current registers, not a pending result.
- IntReq=1: any XOp is ignored that cycle, with no state change. An operation already in RUN is not cancelled and completes normally.
- XOp≠0 while in RUN is a protocol violation, because the hazard unit stalls it. The unit ignores it; the bench flags it as an assertion.
- reset while in RUN: abort at that edge. Busy=0, HI=LO=0, pending result discarded.

## Timing

- Start is same-cycle combinational. Busy rises at the edge that accepts the op.
- The hazard unit stalls a D-stage HI/LO instruction when `Start | Busy`.
- mult: accepted at edge T0. Busy is high in the cycles after T0 through T0+MULT_CYCLES. HI/LO are updated and Busy=0 at edge T0+MULT_CYCLES, so mfhi reaches E the cycle after.
- div: same pattern with DIV_CYCLES (10).
- Back-to-back ops: a new op is accepted at the same edge Busy falls only if XOp is presented while Busy=0. This gives a minimum of one IDLE cycle between consecutive long ops.
- mthi/mtlo: HI/LO are visible the cycle after the write edge.
- XOut has zero latency from HI/LO.

## Test plan

- Reset mid-RUN: start div, assert reset at cycle 4 → next cycle Busy=0, HI=0, LO=0, and no later write occurs.
- Signed mult: A=0xFFFFFFFE, B=3, XOp=1 → Start=1 in that cycle. Busy=1 for exactly 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFA. XOp=7 afterwards gives XOut=0xFFFFFFFF.
- multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA after 5 cycles.
- Signed divide:
  - div A=0xFFFFFFF9 (−7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=0 after mthi 0x11 / mtlo 0x22 → HI=0x11, LO=0x22 unchanged, Busy still high for 10 cycles.
- IntReq suppression:
  - mult with IntReq=1 → Start=0, Busy stays 0, HI/LO unchanged.
  - Start div, then assert IntReq during RUN → the div completes with the correct result.
- Move and overflow-edge cases:
  - mtlo A=0x1234 then, next cycle, XOp=8 → XOut=0x1234.
  - div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.

Source files
------------

// File: rtl/xalu.sv
// HI/LO multiply/divide unit for the E stage. Results are computed when the op
// is accepted, held as a pending value, and committed after a fixed latency.
module xalu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  XOp,
  input  logic        IntReq,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] XOut
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        pend_hi, pend_lo;
  logic               pend_we;

  logic               is_long, is_mul, accept, done, idle_move;
  logic [31:0]        res_hi, res_lo;
  logic               res_we;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        a_mag, b_mag, q_mag, r_mag;
  logic [31:0]        uq, ur;

  assign is_long   = (XOp >= OP_MULT) && (XOp <= OP_DIVU);
  assign is_mul    = (XOp == OP_MULT) || (XOp == OP_MULTU);
  assign Start     = is_long && !IntReq;
  assign accept    = (state == IDLE) && Start;
  assign idle_move = (state == IDLE) && !IntReq;
  assign done      = (state == RUN) && (cnt == CNT_W'(1));

  // Arithmetic for the op being offered this cycle; only captured on accept.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    res_hi = '0;
    res_lo = '0;
    res_we = 1'b1;
    prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u = {32'b0, A} * {32'b0, B};
    // Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN
    // instead of overflowing; remainder takes the dividend's sign.
    a_mag  = A[31] ? (~A + 32'd1) : A;
    b_mag  = B[31] ? (~B + 32'd1) : B;
    q_mag  = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    r_mag  = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    uq     = (B == 32'd0) ? 32'd0 : (A / B);
    ur     = (B == 32'd0) ? 32'd0 : (A % B);
    case (XOp)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_lo = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
        res_hi = A[31] ? (~r_mag + 32'd1) : r_mag;
        res_we = (B != 32'd0);
      end
      OP_DIVU: begin
        res_lo = uq;
        res_hi = ur;
        res_we = (B != 32'd0);
      end
      default: res_we = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so all
    // flops sample the pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Busy = (state == RUN);
  end

  // Counter and pending result
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
    end else if (accept) begin
      cnt     <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      pend_we <= res_we;
    end else if (state == RUN) begin
      cnt <= cnt - CNT_W'(1);
      if (done) pend_we <= 1'b0;
    end
  end

  // Architectural HI/LO: long-op commit or an idle move
  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (done) begin
      if (pend_we) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end else if (idle_move) begin
      if (XOp == OP_MTHI) HI <= A;
      if (XOp == OP_MTLO) LO <= A;
    end
  end

  always_comb begin
    XOut = '0;
    if (XOp == OP_MFHI)      XOut = HI;
    else if (XOp == OP_MFLO) XOut = LO;
  end

endmodule

// File: tb/tb_xalu.sv
// Directed bench for xalu: stimulus pushes expected commits into a scoreboard,
// a monitor pops and compares whenever Busy falls.
module tb_xalu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [3:0]  xop;
  logic        int_req;
  logic        start, busy;
  logic [31:0] hi, lo, xout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   run_len = 0;
  logic prev_busy = 1'b0;

  xalu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(a), .B(b), .XOp(xop), .IntReq(int_req),
    .Start(start), .Busy(busy), .HI(hi), .LO(lo), .XOut(xout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input string tag, input int cycles, input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.tag = tag; e.cycles = cycles; e.hi = h; e.lo = l;
    sb.push_back(e);
  endtask

  // Present one op for one cycle; check Start before the edge, Busy after.
  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic irq, input logic exp_start, input logic exp_busy, input string name);
    @(posedge clk); #1;
    xop = op; a = av; b = bv; int_req = irq;
    #1 check({name, "_start"}, 32'(start), 32'(exp_start));
    @(posedge clk); #1;
    xop = 4'd0; int_req = 1'b0;
    check({name, "_busy"}, 32'(busy), 32'(exp_busy));
  endtask

  task automatic read(input logic [3:0] op, input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    xop = op;
    #1 check(name, xout, exp);
    @(posedge clk); #1;
    xop = 4'd0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 50 && busy; i++) begin
      @(posedge clk); #1;
    end
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Monitor: count Busy-high cycles, compare on each falling edge of Busy.
  initial begin
    forever begin
      @(negedge clk);
      assert (!(busy === 1'b1 && xop != 4'd0 && reset === 1'b0)) else begin
        bad++;
        $display("FAIL protocol: XOp=%0d presented while busy", xop);
      end
      if (busy === 1'b1) run_len++;
      else if (prev_busy === 1'b1) begin
        if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
        else begin
          exp_t e;
          e = sb.pop_front();
          check({e.tag, "_cycles"}, 32'(run_len), 32'(e.cycles));
          check({e.tag, "_hi"}, hi, e.hi);
          check({e.tag, "_lo"}, lo, e.lo);
        end
        run_len = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    reset = 1'b1; a = '0; b = '0; xop = '0; int_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_xout", xout, 32'd0);

    // Reset mid-RUN: preload HI/LO, start div, reset after 4 busy cycles.
    issue(4'd5, 32'hAA, 32'd0, 1'b0, 1'b0, 1'b0, "mthi_aa");
    check("mthi_aa_hi", hi, 32'hAA);
    issue(4'd6, 32'hBB, 32'd0, 1'b0, 1'b0, 1'b0, "mtlo_bb");
    check("mtlo_bb_lo", lo, 32'hBB);
    push("rstrun", 4, 32'd0, 32'd0);
    issue(4'd3, 32'd100, 32'd7, 1'b0, 1'b1, 1'b1, "div_rst");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("rstrun_busy", 32'(busy), 32'd0);
    check("rstrun_hi", hi, 32'd0);
    check("rstrun_lo", lo, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("rstrun_late_hi", hi, 32'd0);
    check("rstrun_late_lo", lo, 32'd0);
    check("rstrun_late_busy", 32'(busy), 32'd0);

    // Signed mult -2 * 3 = -6
    push("mult", 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1, 1'b1, "mult");
    wait_idle("mult");
    read(4'd7, 32'hFFFFFFFF, "mfhi_mult");
    read(4'd8, 32'hFFFFFFFA, "mflo_mult");

    // Unsigned mult 0xFFFFFFFE * 3 = 0x2_FFFFFFFA
    push("multu", 5, 32'h00000002, 32'hFFFFFFFA);
    issue(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1, 1'b1, "multu");
    wait_idle("multu");

    // Signed div -7 / 2 = -3 rem -1
    push("div_neg", 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1, 1'b1, "div_neg");
    wait_idle("div_neg");

    // divu by zero keeps HI/LO but still runs the full latency
    issue(4'd5, 32'h11, 32'd0, 1'b0, 1'b0, 1'b0, "mthi_11");
    issue(4'd6, 32'h22, 32'd0, 1'b0, 1'b0, 1'b0, "mtlo_22");
    push("divu_zero", 10, 32'h11, 32'h22);
    issue(4'd4, 32'd7, 32'd0, 1'b0, 1'b1, 1'b1, "divu_zero");
    wait_idle("divu_zero");

    // mult suppressed by IntReq
    issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0, 1'b0, "mult_irq");
    check("mult_irq_hi", hi, 32'h11);
    check("mult_irq_lo", lo, 32'h22);
    @(posedge clk); #1;
    check("mult_irq_busy2", 32'(busy), 32'd0);

    // IntReq during RUN does not cancel: 100 / -7 = -14 rem 2
    push("div_irqrun", 10, 32'd2, 32'hFFFFFFF2);
    issue(4'd3, 32'd100, 32'hFFFFFFF9, 1'b0, 1'b1, 1'b1, "div_irqrun");
    @(posedge clk); #1 int_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 int_req = 1'b0;
    wait_idle("div_irqrun");

    // mtlo then mflo next cycle
    issue(4'd6, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0, "mtlo_1234");
    read(4'd8, 32'h1234, "mflo_1234");

    // Overflow edge: INT_MIN / -1
    push("div_ovf", 10, 32'd0, 32'h80000000);
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, "div_ovf");
    wait_idle("div_ovf");

    // divu 0xFFFFFFFF / 10 = 0x19999999 rem 5
    push("divu", 10, 32'd5, 32'h19999999);
    issue(4'd4, 32'hFFFFFFFF, 32'd10, 1'b0, 1'b1, 1'b1, "divu");
    wait_idle("divu");
    read(4'd7, 32'd5, "mfhi_divu");

    // Out-of-range XOp acts as none
    issue(4'd12, 32'hDEAD, 32'd1, 1'b0, 1'b0, 1'b0, "xop12");
    check("xop12_hi", hi, 32'd5);

    repeat (3) @(posedge clk);
    #1 check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
